// File: rtl/d1_repl_block.sv
// ---------------------------------------------------------------------------
// d1_repl_block
//
// Tree pseudo-LRU replacement unit for the L1 data cache, stage d1.
// Each set owns N_WAY-1 PLRU bits stored as a heap-indexed binary tree
// (node 0 = root, children of n are 2n+1 / 2n+2). Hits and refills steer
// every node on the accessed way's path away from that way. A lookup
// registers a one-hot victim, preferring the lowest invalid way.
// A flush pulse starts a sweep that clears one set per cycle.
//
// Ports
//   clk_i          : clock
//   rst_i          : asynchronous active-high reset
//   lookup_valid_i : request a victim for set lookup_idx_i
//   lookup_idx_i   : lookup set index
//   valid_vec_i    : valid bits of the looked-up set (valid_vec_t)
//   hit_i          : hit access, update set hit_idx_i
//   hit_idx_i      : hit set index
//   hit_vec_i      : hit lines (hit_vec_t), lowest set bit is used
//   fill_i         : refill done, mark fill_vec_i way as MRU
//   fill_idx_i     : refill set index
//   fill_vec_i     : one-hot refilled way (repl_vec_t)
//   flush_i        : pulse, starts the PLRU clear sweep
//   replace_vec_o  : registered one-hot victim (repl_vec_t)
//   repl_valid_o   : replace_vec_o valid this cycle
//   busy_o         : clear sweep in progress
// ---------------------------------------------------------------------------

package d1_repl_pkg;
  localparam int unsigned DCACHE_L1_ASSOCIATIVITY = 4;
endpackage

module d1_repl_block #(
  parameter int unsigned N_WAY = d1_repl_pkg::DCACHE_L1_ASSOCIATIVITY,
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lookup_valid_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  input  logic [N_WAY-1:0] valid_vec_i,
  input  logic             hit_i,
  input  logic [IDX_W-1:0] hit_idx_i,
  input  logic [N_WAY-1:0] hit_vec_i,
  input  logic             fill_i,
  input  logic [IDX_W-1:0] fill_idx_i,
  input  logic [N_WAY-1:0] fill_vec_i,
  input  logic             flush_i,
  output logic [N_WAY-1:0] replace_vec_o,
  output logic             repl_valid_o,
  output logic             busy_o
);

  localparam int unsigned NUM_SETS = 1 << IDX_W;
  localparam int unsigned WAY_W    = $clog2(N_WAY);
  localparam int unsigned NODES    = N_WAY - 1;
  localparam logic [IDX_W-1:0] LAST_SET = '1;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  // Steer every node on the path to `way` away from it. A leaf that is a
  // left (odd-numbered) child sits in its parent's lower half, so the parent
  // must point to the upper half (1); a right child makes the parent 0.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
    logic [NODES-1:0] r;
    int unsigned      node;
    r    = bits;
    node = 32'(way) + NODES;
    for (int l = 0; l < int'(WAY_W); l++) begin
      r[(node - 1) / 2] = (node % 2 == 1);
      node = (node - 1) / 2;
    end
    return r;
  endfunction

  // Follow the node bits from the root down; leaves NODES..2*NODES map to
  // ways 0..N_WAY-1 in order.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
    int unsigned node;
    node = 0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      node = 2 * node + 1 + (bits[node] ? 1 : 0);
    end
    return WAY_W'(node - NODES);
  endfunction

  function automatic logic [WAY_W-1:0] lowest_set(input logic [N_WAY-1:0] v);
    logic [WAY_W-1:0] r;
    r = '0;
    for (int i = int'(N_WAY) - 1; i >= 0; i--) begin
      if (v[i]) r = WAY_W'(i);
    end
    return r;
  endfunction

  // PLRU storage: flop array, since the reset must clear it asynchronously.
  logic [NODES-1:0] plru_reg [NUM_SETS];

  state_t           state_reg;
  logic [IDX_W-1:0] sweep_cnt_reg;
  logic             busy_reg;
  logic [N_WAY-1:0] replace_vec_reg;
  logic             repl_valid_reg;

  logic             sweeping;
  logic             last_sweep;
  logic             lookup_acc;
  logic             fill_en;
  logic             hit_en;
  logic [NODES-1:0] lookup_bits;
  logic [N_WAY-1:0] replace_next;
  logic [NODES-1:0] hit_plru_next;
  logic [NODES-1:0] fill_plru_next;

  assign sweeping   = (state_reg == ST_SWEEP);
  assign last_sweep = sweeping && (sweep_cnt_reg == LAST_SET);
  // The lookup sampled on the edge that ends the sweep is already served.
  assign lookup_acc = lookup_valid_i && (!sweeping || last_sweep);
  assign fill_en    = fill_i && !sweeping && (|fill_vec_i);
  // A fill to the same set wins over the hit.
  assign hit_en     = hit_i && !sweeping && (|hit_vec_i)
                      && !(fill_i && (fill_idx_i == hit_idx_i));

  always_comb begin
    lookup_bits = plru_reg[lookup_idx_i];
    // On the final sweep cycle the set being cleared must read as cleared.
    if (sweeping && (lookup_idx_i == sweep_cnt_reg)) lookup_bits = '0;

    replace_next = '0;
    if (!(&valid_vec_i)) replace_next[lowest_set(~valid_vec_i)] = 1'b1;
    else                 replace_next[plru_victim(lookup_bits)] = 1'b1;

    hit_plru_next  = plru_touch(plru_reg[hit_idx_i], lowest_set(hit_vec_i));
    fill_plru_next = plru_touch(plru_reg[fill_idx_i], lowest_set(fill_vec_i));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < int'(NUM_SETS); s++) plru_reg[s] <= '0;
    end else if (sweeping) begin
      plru_reg[sweep_cnt_reg] <= '0;
    end else begin
      if (hit_en)  plru_reg[hit_idx_i]  <= hit_plru_next;
      if (fill_en) plru_reg[fill_idx_i] <= fill_plru_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      sweep_cnt_reg   <= '0;
      busy_reg        <= 1'b0;
      replace_vec_reg <= '0;
      repl_valid_reg  <= 1'b0;
    end else begin
      repl_valid_reg <= lookup_acc;
      if (lookup_acc) replace_vec_reg <= replace_next;

      case (state_reg)
        ST_IDLE: begin
          if (flush_i) begin
            state_reg     <= ST_SWEEP;
            sweep_cnt_reg <= '0;
            busy_reg      <= 1'b1;
          end
        end
        ST_SWEEP: begin
          // Counter wraps back to 0 after the last set.
          sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
          if (last_sweep) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign replace_vec_o = replace_vec_reg;
  assign repl_valid_o  = repl_valid_reg;
  assign busy_o        = busy_reg;

endmodule

// File: tb/tb_d1_repl_block.sv
// ---------------------------------------------------------------------------
// tb_d1_repl_block
//
// Directed bench for d1_repl_block (N_WAY=4, IDX_W=7). Expected victims are
// hand-derived from the tree-PLRU rules; every comparison goes through
// check_eq, which prints one line per comparison.
// ---------------------------------------------------------------------------

module tb_d1_repl_block;

  localparam int N_WAY = 4;
  localparam int IDX_W = 7;

  logic             clk;
  logic             rst;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_idx;
  logic [N_WAY-1:0] valid_vec;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [N_WAY-1:0] hit_vec;
  logic             fill;
  logic [IDX_W-1:0] fill_idx;
  logic [N_WAY-1:0] fill_vec;
  logic             flush;
  logic [N_WAY-1:0] replace_vec;
  logic             repl_valid;
  logic             busy;

  int n_checks;
  int n_fail;
  int busy_cnt;

  d1_repl_block #(
    .N_WAY(N_WAY),
    .IDX_W(IDX_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .lookup_valid_i(lookup_valid),
    .lookup_idx_i  (lookup_idx),
    .valid_vec_i   (valid_vec),
    .hit_i         (hit),
    .hit_idx_i     (hit_idx),
    .hit_vec_i     (hit_vec),
    .fill_i        (fill),
    .fill_idx_i    (fill_idx),
    .fill_vec_i    (fill_vec),
    .flush_i       (flush),
    .replace_vec_o (replace_vec),
    .repl_valid_o  (repl_valid),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: observed %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [IDX_W-1:0] idx, input logic [N_WAY-1:0] vv,
                           input logic [31:0] exp, input string tag);
    lookup_valid = 1'b1;
    lookup_idx   = idx;
    valid_vec    = vv;
    step();
    lookup_valid = 1'b0;
    check_eq({tag, ".valid"}, 32'(repl_valid), 32'd1);
    check_eq({tag, ".vec"}, 32'(replace_vec), exp);
  endtask

  task automatic do_hit(input logic [IDX_W-1:0] idx, input logic [N_WAY-1:0] hv);
    hit     = 1'b1;
    hit_idx = idx;
    hit_vec = hv;
    step();
    hit = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    lookup_valid = 1'b0; lookup_idx = '0; valid_vec = '1;
    hit = 1'b0; hit_idx = '0; hit_vec = '0;
    fill = 1'b0; fill_idx = '0; fill_vec = '0;
    flush = 1'b0;
    step();
    step();
    check_eq("rst.replace_vec", 32'(replace_vec), 32'd0);
    check_eq("rst.repl_valid", 32'(repl_valid), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Reset default victim, then one-cycle valid pulse with held vector.
    do_lookup(5, 4'b1111, 32'b0001, "dflt5");
    step();
    check_eq("dflt5.valid_drop", 32'(repl_valid), 32'd0);
    check_eq("dflt5.vec_hold", 32'(replace_vec), 32'b0001);

    // Invalid-first: PLRU of idx 9 trained to victim way 1.
    do_hit(9, 4'b0001);
    do_hit(9, 4'b0100);
    do_lookup(9, 4'b1011, 32'b0100, "inv9.1011");
    do_lookup(9, 4'b0111, 32'b1000, "inv9.0111");
    do_lookup(9, 4'b0000, 32'b0001, "inv9.0000");
    do_lookup(9, 4'b1111, 32'b0010, "plru9");

    // PLRU sequences.
    do_hit(3, 4'b0010);
    do_hit(3, 4'b0100);
    do_hit(3, 4'b1000);
    do_lookup(3, 4'b1111, 32'b0001, "seq3");
    do_hit(4, 4'b0001);
    do_hit(4, 4'b0100);
    do_lookup(4, 4'b1111, 32'b0010, "seq4");
    do_lookup(3, 4'b1111, 32'b0001, "seq3.isolated");
    do_hit(4, 4'b0000);
    do_lookup(4, 4'b1111, 32'b0010, "seq4.zero_hit");
    do_hit(12, 4'b0110);
    do_lookup(12, 4'b1111, 32'b0100, "hit12.lowest_bit");

    // Lookup and hit to the same set in one cycle: old state answers.
    apply_reset();
    lookup_valid = 1'b1; lookup_idx = 6; valid_vec = 4'b1111;
    hit = 1'b1; hit_idx = 6; hit_vec = 4'b0001;
    step();
    lookup_valid = 1'b0; hit = 1'b0;
    check_eq("same6.valid", 32'(repl_valid), 32'd1);
    check_eq("same6.old", 32'(replace_vec), 32'b0001);
    do_lookup(6, 4'b1111, 32'b0100, "same6.new");

    // Fill and hit to the same set: fill only.
    apply_reset();
    fill = 1'b1; fill_idx = 7; fill_vec = 4'b0010;
    hit = 1'b1; hit_idx = 7; hit_vec = 4'b0100;
    step();
    fill = 1'b0; hit = 1'b0;
    do_lookup(7, 4'b1111, 32'b0100, "fillhit7");

    // Fill and hit to different sets: both applied.
    fill = 1'b1; fill_idx = 10; fill_vec = 4'b0001;
    hit = 1'b1; hit_idx = 11; hit_vec = 4'b0010;
    step();
    fill = 1'b0; hit = 1'b0;
    do_lookup(10, 4'b1111, 32'b0100, "split.fill10");
    do_lookup(11, 4'b1111, 32'b0100, "split.hit11");

    // Flush sweep.
    do_hit(0, 4'b0001);
    do_hit(127, 4'b0010);
    do_lookup(0, 4'b1111, 32'b0100, "pre_flush0");
    do_lookup(127, 4'b1111, 32'b0100, "pre_flush127");
    flush = 1'b1;
    lookup_valid = 1'b1; lookup_idx = 0; valid_vec = 4'b1111;
    step();
    flush = 1'b0; lookup_valid = 1'b0;
    check_eq("flush.same_cycle.valid", 32'(repl_valid), 32'd1);
    check_eq("flush.same_cycle.vec", 32'(replace_vec), 32'b0100);
    busy_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (!busy) break;
      busy_cnt++;
      case (c)
        10: begin
          lookup_valid = 1'b1; lookup_idx = 0; valid_vec = 4'b1111;
          hit = 1'b1; hit_idx = 0; hit_vec = 4'b0010;
          fill = 1'b1; fill_idx = 1; fill_vec = 4'b0001;
        end
        11: begin
          lookup_valid = 1'b0; hit = 1'b0; fill = 1'b0;
          check_eq("sweep.lookup_ignored", 32'(repl_valid), 32'd0);
          check_eq("sweep.vec_hold", 32'(replace_vec), 32'b0100);
        end
        20: flush = 1'b1;
        21: flush = 1'b0;
        127: begin
          lookup_valid = 1'b1; lookup_idx = 127; valid_vec = 4'b1111;
        end
        default: ;
      endcase
      step();
    end
    lookup_valid = 1'b0;
    check_eq("sweep.busy_cycles", 32'(busy_cnt), 32'd128);
    check_eq("sweep.last_edge_lookup.valid", 32'(repl_valid), 32'd1);
    check_eq("sweep.last_edge_lookup.vec", 32'(replace_vec), 32'b0001);
    do_lookup(0, 4'b1111, 32'b0001, "post_flush0");
    do_lookup(1, 4'b1111, 32'b0001, "post_flush1");
    do_lookup(127, 4'b1111, 32'b0001, "post_flush127");

    // Reset in the middle of a sweep.
    do_hit(100, 4'b0001);
    do_lookup(100, 4'b1111, 32'b0100, "pre_rst100");
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (50) step();
    check_eq("midsweep.busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midsweep.async_busy", 32'(busy), 32'd0);
    check_eq("midsweep.async_valid", 32'(repl_valid), 32'd0);
    check_eq("midsweep.async_vec", 32'(replace_vec), 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int s = 0; s < 128; s++) begin
      do_lookup(IDX_W'(s), 4'b1111, 32'b0001, $sformatf("post_rst_set%0d", s));
    end
    check_eq("post_rst.busy", 32'(busy), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("reflush.busy_rise", 32'(busy), 32'd1);
    busy_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (!busy) break;
      busy_cnt++;
      step();
    end
    check_eq("reflush.busy_cycles", 32'(busy_cnt), 32'd128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
